xor_stream_acc: RTL and testbench
=================================

# xor_stream_acc

Parametrised streaming XOR stage with a per-frame checksum accumulator. It generalises the team's single-bit 2-input XOR to WIDTH-bit operand words on a valid/ready stream. Each beat produces c = a ^ b through one registered output stage. A running XOR of all c words in the current frame is kept, so the last beat of a frame carries the frame checksum and beat count. It sits between a word source and any consumer that needs combined data plus integrity info, e.g. UART/LED demo datapaths.

## Interface
- WIDTH, 8, operand/result word width in bits (≥1)
- CNT_W, 8, width of the per-frame beat counter (≥1)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_last  input  1  beat is the last of its frame
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts the output beat
- c  output  WIDTH  a ^ b of the presented beat
- out_last  output  1  presented beat is frame-last
- acc  output  WIDTH  XOR of all c in the frame up to and including the presented beat
- beats  output  CNT_W  1-based beat index within the frame, saturating
- par  output  1  even parity of c (^c); present only with XOR_PARITY_EN

## Operation
- Accept: acc_in = in_valid & in_ready. Emit: out_valid & out_ready.
- in_ready = !out_valid | out_ready, so throughput is one beat per cycle. in_ready does not depend on in_valid.
- On accept, the output register loads:
  - c ← a^b
  - out_last ← in_last
  - out_valid ← 1
- On emit without accept: out_valid ← 0. All data outputs hold their last value.
- State machine, frame tracking:
  - IDLE: no partial frame. An accept with in_last=0 goes to FRAME. An accept with in_last=1 stays in IDLE.
  - FRAME: an accept with in_last=1 goes to IDLE.
- Running register run, WIDTH bits, and counter cnt, CNT_W bits. On accept:
  - In IDLE: acc ← a^b and beats ← 1.
  - In FRAME: acc ← run ^ a ^ b and beats ← sat(cnt+1). sat() holds all-ones once reached, with no wrap.
  - If in_last=1: run ← 0 and cnt ← 0.
  - Otherwise: run ← the new acc value and cnt ← the new beats value.
- On the out_last beat, acc is therefore the full frame checksum and beats is the frame length, saturated.
- While out_valid=1 and out_ready=0: c, out_last, acc, beats (and par) hold stable. No input is accepted.
- Single-beat frame (in_last=1 in IDLE): acc = c and beats = 1.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is presented from edge N onward, i.e. visible in cycle N+1.
- Simultaneous emit and accept in the same cycle: the new beat replaces the old one. out_valid stays 1 and there is no bubble.
- Reset values, asserted asynchronously while rst_n=0:
  - out_valid=0, c=0, out_last=0, acc=0, beats=0, par=0
  - run=0, cnt=0, state=IDLE
  - in_ready=1, since it follows from out_valid=0
- Reset mid-frame discards the partial frame and any presented beat. The first beat after reset starts a new frame.
- Deassertion of rst_n is synchronised externally. The block adds no reset synchroniser.

## Configuration
- XOR_PARITY_EN defined:
  - The par port exists and is registered with c: par ← ^(a^b) on accept.
  - par holds during stall and resets to 0.
- XOR_PARITY_EN undefined:
  - The par port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then WIDTH=8 single beat a=0xF0, b=0x3C, in_last=1, out_ready=1 -> next cycle out_valid=1, c=0xCC, acc=0xCC, beats=1, out_last=1 (par=0 with XOR_PARITY_EN).
- Frame of 3 beats, c values 0x01, 0x02, 0x04, streamed back-to-back with out_ready=1 -> acc sequence 0x01, 0x03, 0x07; beats 1, 2, 3; out_last only on the third beat; in_ready stays 1 throughout.
- Hold out_ready=0 for 4 cycles with a beat presented -> in_ready=0, all outputs stable. Raise out_ready with in_valid=1 -> emit and accept in the same cycle, no bubble.
- CNT_W=2 frame of 6 beats -> beats = 1, 2, 3, 3, 3, 3, saturated with no wrap. acc on the last beat equals the XOR of all 6 c values.
- Assert rst_n=0 mid-frame after 2 beats, then release and send a 1-beat frame c=0x55 -> all outputs were 0 during reset. New output: acc=0x55, beats=1, with no prior-frame contribution.

Source files
------------

// File: rtl/xor_stream_acc.sv
// Streaming WIDTH-bit XOR stage with one registered output slot and a per-frame XOR checksum / beat counter.
// Optional parity output: define XOR_PARITY_EN to add the registered par port (^c).
module xor_stream_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             out_last,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] beats
`ifdef XOR_PARITY_EN
  ,
  output logic             par
`endif
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_out_last;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_beats;
  logic [WIDTH-1:0] r_run;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_new_acc;
  logic [CNT_W-1:0] w_new_beats;
  logic [CNT_W-1:0] w_cnt_sat;

  // Slot frees up whenever it is empty or being drained this cycle.
  assign w_in_ready  = !r_out_valid || out_ready;
  assign w_accept    = in_valid && w_in_ready;
  assign w_x         = a ^ b;
  assign w_cnt_sat   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_new_acc   = (r_state == FRAME) ? (r_run ^ w_x) : w_x;
  assign w_new_beats = (r_state == FRAME) ? w_cnt_sat : CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_out_last  <= 1'b0;
      r_acc       <= '0;
      r_beats     <= '0;
      r_run       <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_c         <= w_x;
      r_out_last  <= in_last;
      r_acc       <= w_new_acc;
      r_beats     <= w_new_beats;
      if (in_last) begin
        r_state <= IDLE;
        r_run   <= '0;
        r_cnt   <= '0;
      end else begin
        r_state <= FRAME;
        r_run   <= w_new_acc;
        r_cnt   <= w_new_beats;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef XOR_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_par <= 1'b0;
    else if (w_accept) r_par <= ^w_x;
  end
  assign par = r_par;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign out_last  = r_out_last;
  assign acc       = r_acc;
  assign beats     = r_beats;

endmodule

// File: tb/tb_xor_stream_acc.sv
// Directed bench: default-size instance plus a CNT_W=2 instance sharing the same input stream.
module tb_xor_stream_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] a, b;

  logic       rdy0, ov0, ol0;
  logic [7:0] c0, acc0, bt0;
  logic       rdy1, ov1, ol1;
  logic [7:0] c1, acc1;
  logic [1:0] bt1;
`ifdef XOR_PARITY_EN
  logic       par0, par1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xor_stream_acc #(.WIDTH(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .c(c0), .out_last(ol0), .acc(acc0), .beats(bt0)
`ifdef XOR_PARITY_EN
    , .par(par0)
`endif
  );

  xor_stream_acc #(.WIDTH(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .c(c1), .out_last(ol1), .acc(acc1), .beats(bt1)
`ifdef XOR_PARITY_EN
    , .par(par1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] ta, input logic [7:0] tb, input logic tl);
    in_valid = 1'b1; a = ta; b = tb; in_last = tl;
  endtask

  logic [7:0] exp_acc6 [6];
  logic [1:0] exp_bt1  [6];

  initial begin
    exp_acc6 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
    exp_bt1  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_out_valid", ov0, 0);
    chk("rst_c", c0, 0);
    chk("rst_acc", acc0, 0);
    chk("rst_beats", bt0, 0);
    chk("rst_out_last", ol0, 0);
    chk("rst_in_ready", rdy0, 1);
`ifdef XOR_PARITY_EN
    chk("rst_par", par0, 0);
`endif
    step(); step();
    rst_n = 1'b1;
    step();

    // Single-beat frame.
    out_ready = 1'b1;
    beat(8'hF0, 8'h3C, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", ov0, 1);
    chk("t1_c", c0, 8'hCC);
    chk("t1_acc", acc0, 8'hCC);
    chk("t1_beats", bt0, 1);
    chk("t1_out_last", ol0, 1);
`ifdef XOR_PARITY_EN
    chk("t1_par", par0, 0);
`endif
    step();
    chk("t1_drain", ov0, 0);

    // Three-beat frame, back to back.
    beat(8'h01, 8'h00, 1'b0);
    chk("t2_rdy0", rdy0, 1);
    step();
    chk("t2_acc0", acc0, 8'h01);
    chk("t2_beats0", bt0, 1);
    chk("t2_last0", ol0, 0);
`ifdef XOR_PARITY_EN
    chk("t2_par0", par0, 1);
`endif
    beat(8'h03, 8'h01, 1'b0);
    chk("t2_rdy1", rdy0, 1);
    step();
    chk("t2_c1", c0, 8'h02);
    chk("t2_acc1", acc0, 8'h03);
    chk("t2_beats1", bt0, 2);
    chk("t2_last1", ol0, 0);
    beat(8'h0C, 8'h08, 1'b1);
    chk("t2_rdy2", rdy0, 1);
    step();
    in_valid = 1'b0;
    chk("t2_c2", c0, 8'h04);
    chk("t2_acc2", acc0, 8'h07);
    chk("t2_beats2", bt0, 3);
    chk("t2_last2", ol0, 1);
    step();
    chk("t2_drain", ov0, 0);

    // Backpressure: hold a presented beat for 4 cycles.
    out_ready = 1'b0;
    beat(8'h10, 8'h00, 1'b0);
    step();
    beat(8'h20, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_in_ready", rdy0, 0);
      chk("t3_out_valid", ov0, 1);
      chk("t3_c", c0, 8'h10);
      chk("t3_acc", acc0, 8'h10);
      chk("t3_beats", bt0, 1);
      chk("t3_last", ol0, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_rdy_release", rdy0, 1);
    step();
    in_valid = 1'b0;
    chk("t3_nobubble", ov0, 1);
    chk("t3_c2", c0, 8'h20);
    chk("t3_acc2", acc0, 8'h30);
    chk("t3_beats2", bt0, 2);
    chk("t3_last2", ol0, 1);
    step();

    // Six-beat frame: CNT_W=2 saturates at 3, CNT_W=8 counts to 6.
    for (int i = 0; i < 6; i++) begin
      beat(8'(1 << i), 8'h00, i == 5);
      step();
      chk("t4_acc0", acc0, exp_acc6[i]);
      chk("t4_beats0", bt0, i + 1);
      chk("t4_acc1", acc1, exp_acc6[i]);
      chk("t4_beats1", bt1, exp_bt1[i]);
      chk("t4_last1", ol1, i == 5);
    end
    in_valid = 1'b0;
    step();

    // Reset mid-frame, then a fresh single-beat frame.
    beat(8'h11, 8'h00, 1'b0);
    step();
    beat(8'h22, 8'h00, 1'b0);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ov", ov0, 0);
    chk("t5_rst_c", c0, 0);
    chk("t5_rst_acc", acc0, 0);
    chk("t5_rst_beats", bt0, 0);
    chk("t5_rst_beats1", bt1, 0);
    step();
    rst_n = 1'b1;
    step();
    beat(8'h55, 8'h00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t5_ov", ov0, 1);
    chk("t5_c", c0, 8'h55);
    chk("t5_acc", acc0, 8'h55);
    chk("t5_beats", bt0, 1);
    chk("t5_last", ol0, 1);
    chk("t5_acc1", acc1, 8'h55);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
